subarray_job_scheduler: RTL and testbench

//  Shares one systolic_subarray between NUM_REQ requesters. Round-robin arbitrates job

---
 rtl/subarray_job_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_subarray_job_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subarray_job_scheduler.sv
// -----------------------------------------------------------------------------
// subarray_job_scheduler
// Shares one systolic subarray between NUM_REQ job sources. A round-robin
// arbiter picks one pending job descriptor, latches its SRAM base addresses,
// pulses tpu_start, waits for a rising edge of tpu_done (or a watchdog
// timeout) and returns a one-cycle completion pulse to the granted requester.
// Every output is a register; srst is synchronous and active-high.
// -----------------------------------------------------------------------------
module subarray_job_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_w_base,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_d_base,
    output logic [NUM_REQ-1:0]            done_valid,
    output logic                          done_err,
    output logic                          tpu_start,
    input  logic                          tpu_done,
    output logic                          sub_abort,
    output logic [ADDR_WIDTH-1:0]         w_base,
    output logic [ADDR_WIDTH-1:0]         d_base,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic [CNT_WIDTH-1:0]          jobs_done,
    output logic [CNT_WIDTH-1:0]          jobs_err
);

    localparam int ID_W = $clog2(NUM_REQ);
    // Run counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int TW   = $clog2(TIMEOUT_CYCLES);

    localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]    LAST_ID      = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0    = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t                r_state;
    logic [ID_W-1:0]       r_rr;
    logic [TW-1:0]         r_cnt;
    logic                  r_tpu_done_q;

    logic [NUM_REQ-1:0]    r_req_ready;
    logic [NUM_REQ-1:0]    r_done_valid;
    logic                  r_done_err;
    logic                  r_tpu_start;
    logic                  r_sub_abort;
    logic [ADDR_WIDTH-1:0] r_w_base;
    logic [ADDR_WIDTH-1:0] r_d_base;
    logic                  r_busy;
    logic [ID_W-1:0]       r_grant_id;
    logic [CNT_WIDTH-1:0]  r_jobs_done;
    logic [CNT_WIDTH-1:0]  r_jobs_err;

    // -------------------------------------------------------------------------
    // Combinational arbitration signals
    // -------------------------------------------------------------------------
    logic                  w_any;
    logic                  w_hi_found;
    logic [ID_W-1:0]       w_win_lo;
    logic [ID_W-1:0]       w_win_hi;
    logic [ID_W-1:0]       w_win;
    logic [ADDR_WIDTH-1:0] w_win_w;
    logic [ADDR_WIDTH-1:0] w_win_d;
    logic                  w_done_seen;
    logic                  w_timeout;

    assign w_done_seen = tpu_done & ~r_tpu_done_q;
    assign w_timeout   = (r_cnt == TIMEOUT_LAST);

    // Round-robin pick: lowest pending index at or above the pointer, else
    // wrap around to the lowest pending index overall.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        w_any      = 1'b0;
        w_hi_found = 1'b0;
        w_win_lo   = '0;
        w_win_hi   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any    = 1'b1;
                w_win_lo = ID_W'(i);
            end
            if (req_valid[i] && (ID_W'(i) >= r_rr)) begin
                w_hi_found = 1'b1;
                w_win_hi   = ID_W'(i);
            end
        end
        w_win = w_hi_found ? w_win_hi : w_win_lo;
    end

    // Select the winner's descriptor slices from the packed request buses.
    always_comb begin
        w_win_w = '0;
        w_win_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_win) begin
                w_win_w = req_w_base[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_win_d = req_d_base[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Previous-cycle copy of tpu_done for rising-edge detection, every state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (srst) begin
            r_tpu_done_q <= 1'b0;
        end else begin
            r_tpu_done_q <= tpu_done;
        end
    end

    // Job FSM with registered outputs: grant, start, run/watchdog, complete.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= ST_IDLE;
            r_rr         <= '0;
            r_cnt        <= '0;
            r_req_ready  <= '0;
            r_done_valid <= '0;
            r_done_err   <= 1'b0;
            r_tpu_start  <= 1'b0;
            r_sub_abort  <= 1'b0;
            r_w_base     <= '0;
            r_d_base     <= '0;
            r_busy       <= 1'b0;
            r_grant_id   <= '0;
            r_jobs_done  <= '0;
            r_jobs_err   <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle; only the state that owns a pulse raises it.
            r_req_ready  <= '0;
            r_done_valid <= '0;
            r_tpu_start  <= 1'b0;
            r_sub_abort  <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state     <= ST_START;
                        r_busy      <= 1'b1;
                        r_grant_id  <= w_win;
                        r_w_base    <= w_win_w;
                        r_d_base    <= w_win_d;
                        r_tpu_start <= 1'b1;
                        r_req_ready <= ONE_HOT_0 << w_win;
                        if (w_win == LAST_ID) begin
                            r_rr <= '0;
                        end else begin
                            r_rr <= w_win + 1'b1;
                        end
                    end
                end

                ST_START: begin
                    r_cnt   <= '0;
                    r_state <= ST_RUN;
                end

                ST_RUN: begin
                    // A real completion wins over a coincident timeout.
                    if (w_done_seen) begin
                        r_state      <= ST_DONE;
                        r_done_valid <= ONE_HOT_0 << r_grant_id;
                        r_done_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state      <= ST_DONE;
                        r_done_valid <= ONE_HOT_0 << r_grant_id;
                        r_done_err   <= 1'b1;
                        r_sub_abort  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_done_err <= 1'b0;
                    if (r_jobs_done != {CNT_WIDTH{1'b1}}) begin
                        r_jobs_done <= r_jobs_done + 1'b1;
                    end
                    if (r_done_err && (r_jobs_err != {CNT_WIDTH{1'b1}})) begin
                        r_jobs_err <= r_jobs_err + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output ports
    // -------------------------------------------------------------------------
    assign req_ready  = r_req_ready;
    assign done_valid = r_done_valid;
    assign done_err   = r_done_err;
    assign tpu_start  = r_tpu_start;
    assign sub_abort  = r_sub_abort;
    assign w_base     = r_w_base;
    assign d_base     = r_d_base;
    assign busy       = r_busy;
    assign grant_id   = r_grant_id;
    assign jobs_done  = r_jobs_done;
    assign jobs_err   = r_jobs_err;

endmodule

// File: tb/tb_subarray_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_subarray_job_scheduler
// Directed bench for the subarray job scheduler. Expected completions are
// pushed to a scoreboard queue when a job is requested and popped when the
// DUT raises done_valid. Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_subarray_job_scheduler;

    localparam int NUM_REQ = 2;
    localparam int AW      = 10;
    localparam int TO      = 8;
    localparam int CW      = 16;

    logic                  clk = 1'b0;
    logic                  srst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_w_base;
    logic [NUM_REQ*AW-1:0] req_d_base;
    logic [NUM_REQ-1:0]    done_valid;
    logic                  done_err;
    logic                  tpu_start;
    logic                  tpu_done;
    logic                  sub_abort;
    logic [AW-1:0]         w_base;
    logic [AW-1:0]         d_base;
    logic                  busy;
    logic                  grant_id;
    logic [CW-1:0]         jobs_done;
    logic [CW-1:0]         jobs_err;

    subarray_job_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_w_base (req_w_base),
        .req_d_base (req_d_base),
        .done_valid (done_valid),
        .done_err   (done_err),
        .tpu_start  (tpu_start),
        .tpu_done   (tpu_done),
        .sub_abort  (sub_abort),
        .w_base     (w_base),
        .d_base     (d_base),
        .busy       (busy),
        .grant_id   (grant_id),
        .jobs_done  (jobs_done),
        .jobs_err   (jobs_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   id;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rdy_cnt[NUM_REQ];

    localparam logic [AW-1:0] W0 = 10'h040;
    localparam logic [AW-1:0] D0 = 10'h080;
    localparam logic [AW-1:0] W1 = 10'h3A1;
    localparam logic [AW-1:0] D1 = 10'h2B2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and tally req_ready pulses seen after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] === 1'b1) rdy_cnt[i]++;
        end
    endtask

    task automatic do_reset();
        srst      = 1'b1;
        req_valid = '0;
        tpu_done  = 1'b0;
        tick();
        tick();
        srst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
    endtask

    task automatic wait_start(input string tag, input int exp_id, input int budget);
        int n;
        n = 0;
        while (tpu_start !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, tpu_start, 1);
        check({tag, "_grant_id"}, grant_id, exp_id);
        check({tag, "_req_ready"}, req_ready, 1 << exp_id);
        check({tag, "_w_base"}, w_base, (exp_id == 0) ? W0 : W1);
        check({tag, "_d_base"}, d_base, (exp_id == 0) ? D0 : D1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (done_valid === '0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, (done_valid !== '0), 1);
        check({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_done_valid"}, done_valid, 1 << e.id);
            check({tag, "_done_err"}, done_err, e.err);
            check({tag, "_sub_abort"}, sub_abort, e.err);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        srst       = 1'b1;
        req_valid  = '0;
        tpu_done   = 1'b0;
        req_w_base = {W1, W0};
        req_d_base = {D1, D0};
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_outputs",
              {req_ready, done_valid, done_err, tpu_start, sub_abort, busy, grant_id, w_base, d_base}, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_jobs_err", jobs_err, 0);
        srst = 1'b0;

        // ---- 1: single job, tpu_done rises 5 cycles after tpu_start ----
        req_valid = 2'b01;
        exp_q.push_back('{id: 0, err: 1'b0});
        tick();                                   // cycle 1
        check("t1_start_c1", tpu_start, 1);
        check("t1_ready_c1", req_ready, 2'b01);
        check("t1_w_base", w_base, W0);
        check("t1_d_base", d_base, D0);
        check("t1_busy", busy, 1);
        req_valid = 2'b00;
        tick();                                   // cycle 2
        check("t1_start_one_cycle", {tpu_start, req_ready}, 0);
        repeat (4) tick();                        // cycle 6
        check("t1_no_early_done", done_valid, 0);
        tpu_done = 1'b1;
        tick();                                   // cycle 7
        wait_done("t1", 0);
        tick();                                   // cycle 8
        check("t1_jobs_done", jobs_done, 1);
        check("t1_jobs_err", jobs_err, 0);
        check("t1_idle", {busy, done_valid}, 0);
        tpu_done = 1'b0;

        // ---- 2: both requesters held, four jobs alternate 0,1,0,1 ----
        do_reset();
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) exp_q.push_back('{id: j % 2, err: 1'b0});
        for (int j = 0; j < 4; j++) begin
            wait_start("t2", j % 2, 8);
            if (j == 3) req_valid = 2'b00;
            tick();                               // RUN
            tpu_done = 1'b1;
            tick();                               // DONE
            tpu_done = 1'b0;
            wait_done("t2", 0);
        end
        tick();
        check("t2_ready_cnt_0", rdy_cnt[0], 2);
        check("t2_ready_cnt_1", rdy_cnt[1], 2);
        check("t2_jobs_done", jobs_done, 4);

        // ---- 3: watchdog timeout with tpu_done held low ----
        do_reset();
        req_valid = 2'b01;
        exp_q.push_back('{id: 0, err: 1'b1});
        tick();                                   // cycle 1
        check("t3_start_c1", tpu_start, 1);
        req_valid = 2'b00;
        for (int c = 2; c <= 9; c++) begin
            tick();
            check("t3_no_done_before_timeout", done_valid, 0);
        end
        tick();                                   // cycle 10 = 9 after tpu_start
        wait_done("t3", 0);
        tick();
        check("t3_idle", busy, 0);
        check("t3_abort_pulse", sub_abort, 0);
        check("t3_jobs_err", jobs_err, 1);
        check("t3_jobs_done", jobs_done, 1);

        // ---- 4: tpu_done held high from a previous job ----
        do_reset();
        req_valid = 2'b01;
        exp_q.push_back('{id: 0, err: 1'b0});
        tick();                                   // START
        req_valid = 2'b00;
        tick();                                   // RUN
        tpu_done = 1'b1;
        tick();                                   // DONE
        wait_done("t4a", 0);
        req_valid = 2'b10;
        exp_q.push_back('{id: 1, err: 1'b0});
        wait_start("t4b", 1, 4);
        req_valid = 2'b00;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4b_held_high_no_done", done_valid, 0);
        end
        tpu_done = 1'b0;
        tick();
        check("t4b_low_no_done", done_valid, 0);
        tpu_done = 1'b1;
        tick();
        wait_done("t4b", 0);
        req_valid = 2'b01;
        exp_q.push_back('{id: 0, err: 1'b1});
        wait_start("t4c", 0, 4);
        req_valid = 2'b00;
        wait_done("t4c", 12);
        tick();
        tpu_done = 1'b0;
        check("t4_jobs_done", jobs_done, 3);
        check("t4_jobs_err", jobs_err, 1);

        // ---- 5: srst during RUN drops the job; pointer restarts at 0 ----
        do_reset();
        req_valid = 2'b11;
        wait_start("t5a", 0, 4);
        tick();                                   // RUN
        tick();                                   // RUN
        srst = 1'b1;
        tick();
        check("t5_rst_outputs",
              {req_ready, done_valid, done_err, tpu_start, sub_abort, busy, grant_id, w_base, d_base}, 0);
        check("t5_rst_jobs", {jobs_done, jobs_err}, 0);
        srst = 1'b0;
        exp_q.push_back('{id: 0, err: 1'b0});
        tick();
        check("t5_no_done_after_rst", done_valid, 0);
        wait_start("t5b", 0, 0);
        req_valid = 2'b00;
        tick();                                   // RUN
        tpu_done = 1'b1;
        tick();                                   // DONE
        wait_done("t5b", 0);
        tick();
        tpu_done = 1'b0;
        check("t5_jobs_done", jobs_done, 1);

        // ---- 6: tpu_done rises exactly when the counter hits TIMEOUT-1 ----
        do_reset();
        req_valid = 2'b01;
        exp_q.push_back('{id: 0, err: 1'b0});
        tick();                                   // cycle 1
        req_valid = 2'b00;
        repeat (8) tick();                        // cycle 9, counter = TO-1
        check("t6_no_done_yet", done_valid, 0);
        tpu_done = 1'b1;
        tick();                                   // cycle 10
        wait_done("t6", 0);
        tick();
        tpu_done = 1'b0;
        check("t6_jobs_err", jobs_err, 0);
        check("t6_jobs_done", jobs_done, 1);
        check("t6_sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
